xbar_out_port: RTL
==================

# xbar_out_port

Crossbar output-port controller sitting directly downstream of the 4-requester round-robin arbiter. It drives the arbiter's request vector, consumes its one-hot grant, locks the grant for the whole packet, and muxes the owning master's valid/ready stream onto the single slave port. It also tags each beat with the source index for response routing and flags oversize packets.

## Interface
- DW, default 32: data width per beat.
- MAX_BEATS, default 16: legal packet length limit, ≥2; used only for overrun flag.
- clk  in  1  clock, all logic on rising edge.
- sreset  in  1  synchronous, active-high reset.
- m_valid  in  4  per-master beat valid.
- m_data  in  4*DW  per-master data, master i at bits [i*DW +: DW].
- m_last  in  4  per-master last-beat marker.
- m_ready  out  4  per-master ready.
- arb_req  out  4  request vector to arbiter.
- arb_grant  in  4  registered one-hot grant from arbiter; 0 = none.
- s_valid  out  1  slave-side valid.
- s_data  out  DW  slave-side data.
- s_last  out  1  slave-side last.
- s_src  out  2  index of owning master.
- s_ready  in  1  slave-side ready.
- pkt_overrun  out  1  sticky: a packet exceeded MAX_BEATS beats.

## Operation
- FSM states IDLE, XFER, RELEASE; reset → IDLE, owner=0, beat_cnt=0, pkt_overrun=0.
- IDLE: hit = |(arb_grant & m_valid). If hit: arb_req = arb_grant (pins arbiter), latch owner = arb_grant, beat_cnt=0, → XFER. Else arb_req = m_valid.
- XFER: arb_req = owner (arbiter holds; bit kept even if owner's m_valid drops). s_valid = |(m_valid & owner); s_data/s_last = owner's m_data/m_last; m_ready = owner & {4{s_ready}}. Beat = s_valid & s_ready. Beat increments beat_cnt (saturating, width clog2(MAX_BEATS)+1). Beat with s_last → RELEASE.
- pkt_overrun sets when a beat occurs with beat_cnt == MAX_BEATS (i.e. beat MAX_BEATS+1 of a packet); cleared only by sreset. Transfer is never cut.
- RELEASE (1 cycle): arb_req = m_valid & ~owner; → IDLE. Arbiter advances past owner; if only owner requests, it returns to owner on the next IDLE pass.
- Outside XFER: s_valid=0, m_ready=0, s_data=0, s_last=0. s_src = encode(owner) always (0 when owner=0).
- sreset high: arb_req=0, all outputs at reset values regardless of state; mid-packet reset abandons the packet, no s_last emitted.
- arb_grant with more than one bit set is illegal; not checked.

## Timing
- Reset values: m_ready=0, arb_req=0 (while sreset high), s_valid=0, s_data=0, s_last=0, s_src=0, pkt_overrun=0.
- Arbiter grant is registered: arb_req in cycle t → arb_grant in t+1.
- Grant-to-first-beat: owner latched at edge ending the IDLE hit cycle; s_valid earliest next cycle.
- Packet turnaround: last beat cycle → RELEASE → IDLE (new grant visible) → XFER: 3 cycles from last beat to next packet's first beat opportunity.
- Single-beat packet (m_last on first beat) legal: XFER one cycle.
- Data path fully combinational from m_* to s_* in XFER (no register); s_ready → m_ready combinational.
- arb_req depends combinationally on arb_grant and m_valid only; no loop, grant is registered.

## Structure
- xbar_pkg: NUM_MASTERS=4, state encoding (IDLE, XFER, RELEASE), onehot-to-index function.
- Sub-module xbar_onehot_mux: DW+1-bit one-hot 4:1 AND-OR mux for data/last.
- Arbiter instantiated by parent, not inside this block.

## Test plan
- Reset: hold sreset 3 cycles with m_valid=4'hF → arb_req=0, s_valid=0, m_ready=0, pkt_overrun=0.
- Single owner: master 2 sends 3-beat packet, s_ready=1 → grant=4'b0100, s_src=2, 3 beats on s_data in order, s_last on beat 3, m_ready[2] only.
- Contention: all masters send 2-beat packets continuously → service order 0,1,2,3,0; no interleaving within a packet; 3-cycle gap after each last.
- Backpressure: s_ready toggles 1,0,0,1 during master 1 packet → m_ready[1] tracks s_ready, s_data held stable while stalled, arb_req stays 4'b0010 throughout.
- Overrun: MAX_BEATS=4, master 0 sends 6 beats → pkt_overrun rises on beat 5 and stays 1 after packet end.
- Reset mid-packet: sreset on beat 2 of 4 → next cycle state IDLE, s_valid=0; after release, fresh arbitration from arb_req=m_valid.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared types and helpers for the crossbar output-port controller.
package xbar_pkg;

  localparam int NUM_MASTERS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } xbar_state_e;

  // OR-reduction encoder; a zero vector maps to index 0.
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (oh[i]) idx = idx | 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/xbar_onehot_mux.sv
// One-hot AND-OR selector across the master lanes; all-zero select yields zero.
module xbar_onehot_mux
  import xbar_pkg::*;
#(
  parameter int W = 33
) (
  input  logic [NUM_MASTERS-1:0]   sel,
  input  logic [NUM_MASTERS*W-1:0] din,
  output logic [W-1:0]             dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      dout = dout | (din[i*W +: W] & {W{sel[i]}});
    end
  end

endmodule

// File: rtl/xbar_out_port.sv
// Crossbar output port: locks the arbiter grant for a whole packet and muxes
// the owning master's stream onto the slave port, tagging beats with the source.
module xbar_out_port
  import xbar_pkg::*;
#(
  parameter int DW        = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic                      clk,
  input  logic                      sreset,
  input  logic [NUM_MASTERS-1:0]    m_valid,
  input  logic [NUM_MASTERS*DW-1:0] m_data,
  input  logic [NUM_MASTERS-1:0]    m_last,
  output logic [NUM_MASTERS-1:0]    m_ready,
  output logic [NUM_MASTERS-1:0]    arb_req,
  input  logic [NUM_MASTERS-1:0]    arb_grant,
  output logic                      s_valid,
  output logic [DW-1:0]             s_data,
  output logic                      s_last,
  output logic [1:0]                s_src,
  input  logic                      s_ready,
  output logic                      pkt_overrun
);

  localparam int CW = $clog2(MAX_BEATS) + 1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  xbar_state_e                state, state_nxt;
  logic [NUM_MASTERS-1:0]     owner, owner_nxt;
  logic [CW-1:0]              beat_cnt, beat_cnt_nxt;
  logic                       ovr_q, ovr_set, hit, beat;
  logic [NUM_MASTERS*(DW+1)-1:0] mux_in;
  logic [DW:0]                mux_out;

  always_comb begin
    mux_in = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      mux_in[i*(DW+1) +: DW+1] = {m_last[i], m_data[i*DW +: DW]};
    end
  end

  xbar_onehot_mux #(.W(DW + 1)) u_mux (
    .sel  (owner),
    .din  (mux_in),
    .dout (mux_out)
  );

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    beat_cnt_nxt = beat_cnt;
    arb_req      = m_valid;
    s_valid      = 1'b0;
    s_data       = '0;
    s_last       = 1'b0;
    m_ready      = '0;
    beat         = 1'b0;
    hit          = |(arb_grant & m_valid);
    case (state)
      IDLE: begin
        if (hit) begin
          // Echo the grant back so the arbiter stays pinned while we lock on.
          arb_req      = arb_grant;
          owner_nxt    = arb_grant;
          beat_cnt_nxt = '0;
          state_nxt    = XFER;
        end
      end
      XFER: begin
        arb_req = owner;
        s_valid = |(m_valid & owner);
        s_data  = mux_out[DW-1:0];
        s_last  = mux_out[DW];
        m_ready = owner & {NUM_MASTERS{s_ready}};
        beat    = s_valid & s_ready;
        if (beat) begin
          beat_cnt_nxt = sat_inc(beat_cnt);
          if (s_last) state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        arb_req   = m_valid & ~owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (sreset) begin
      arb_req = '0;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      m_ready = '0;
    end
  end

  // Overrun flags beat MAX_BEATS+1; the transfer itself continues untouched.
  assign ovr_set     = beat && (beat_cnt == CW'(MAX_BEATS));
  assign pkt_overrun = ovr_q & ~sreset;
  assign s_src       = sreset ? 2'd0 : onehot_to_idx(owner);

  always_ff @(posedge clk) begin
    if (sreset) begin
      state    <= IDLE;
      owner    <= '0;
      beat_cnt <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_cnt_nxt;
      ovr_q    <= ovr_q | ovr_set;
    end
  end

endmodule
